// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family.
package counter_pkg;

  // Limit behaviour selected by sat_mode.
  typedef enum logic {
    MODE_WRAP = 1'b0,
    MODE_SAT  = 1'b1
  } mode_e;

  // Count direction selected by up_down.
  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage : counter_pkg

// File: rtl/counter_next_calc.sv
// Combinational next-count calculation for one enabled step, with limit detection.
module counter_next_calc
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 16,
  parameter int unsigned      STEP_W    = 4,
  parameter logic [WIDTH-1:0] MAX_VALUE = '1
) (
  input  logic [WIDTH-1:0]  count_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              up_down_i,
  input  logic              sat_mode_i,
  output logic [WIDTH-1:0]  next_count_o,
  output logic              limit_event_o
);

  // One extra bit beyond the wider operand so count+step and count+MAX+1 never overflow.
  localparam int unsigned EW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  logic [EW-1:0] cnt_x;
  logic [EW-1:0] step_x;
  logic [EW-1:0] max_x;
  logic [EW-1:0] sum_x;
  logic [EW-1:0] res_x;

  // Step the count up or down, wrapping modulo MAX_VALUE+1 or pinning at the limit.
  always_comb begin
    cnt_x         = EW'(count_i);
    step_x        = EW'(step_i);
    max_x         = EW'(MAX_VALUE);
    sum_x         = cnt_x + step_x;
    res_x         = cnt_x;
    limit_event_o = 1'b0;

    if (up_down_i == DIR_UP) begin
      if (sum_x <= max_x) begin
        res_x = sum_x;
      end else begin
        limit_event_o = 1'b1;
        if (sat_mode_i == MODE_SAT) res_x = max_x;
        else                        res_x = sum_x - max_x - EW'(1);
      end
    end else begin
      if (step_x <= cnt_x) begin
        res_x = cnt_x - step_x;
      end else begin
        limit_event_o = 1'b1;
        if (sat_mode_i == MODE_SAT) res_x = '0;
        else                        res_x = cnt_x + max_x + EW'(1) - step_x;
      end
    end

    next_count_o = WIDTH'(res_x);
  end

endmodule : counter_next_calc

// File: rtl/counter_nbit_updown.sv
// Parametrised load/up/down counter with modulus limit, wrap/saturate mode and event flags.
module counter_nbit_updown
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      STEP_W      = 4,
  parameter logic [WIDTH-1:0] MAX_VALUE   = '1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WIDTH-1:0]  datain,
  input  logic              enable,
  input  logic              up_down,
  input  logic [STEP_W-1:0] step,
  input  logic              sat_mode,
  input  logic              clear_flag,
  output logic [WIDTH-1:0]  dataout,
  output logic              wrap,
  output logic              overflow,
  output logic              at_max,
  output logic              at_min
);

  localparam int unsigned CW = ((WIDTH > STEP_W) ? WIDTH : STEP_W) + 1;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] calc_next;
  logic             calc_event;

  counter_next_calc #(
    .WIDTH     (WIDTH),
    .STEP_W    (STEP_W),
    .MAX_VALUE (MAX_VALUE)
  ) u_next_calc (
    .count_i       (count_q),
    .step_i        (step),
    .up_down_i     (up_down),
    .sat_mode_i    (sat_mode),
    .next_count_o  (calc_next),
    .limit_event_o (calc_event)
  );

  // Load (clamped) beats enable beats hold; any limit event sets the sticky flag over a clear.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q & ~clear_flag;

    if (load) begin
      if (datain > MAX_VALUE) begin
        count_d = MAX_VALUE;
        wrap_d  = 1'b1;
      end else begin
        count_d = datain;
      end
    end else if (enable) begin
      count_d = calc_next;
      wrap_d  = calc_event;
    end

    if (wrap_d) ovf_d = 1'b1;
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= RESET_VALUE;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign dataout  = count_q;
  assign wrap     = wrap_q;
  assign overflow = ovf_q;
  assign at_max   = (count_q == MAX_VALUE);
  assign at_min   = (count_q == '0);

  // A step larger than the modulus has no defined result.
  a_step_legal : assert property (@(posedge clk) disable iff (reset)
    (enable && !load) |-> (CW'(step) <= CW'(MAX_VALUE)));

endmodule : counter_nbit_updown

// File: tb/tb_counter_nbit_updown.sv
// Self-checking bench: two counters (modulus 10 and full 8-bit) driven by shared stimulus
// and compared every cycle against an integer reference model.
module tb_counter_nbit_updown;

  logic       clk = 1'b0;
  logic       reset, load, enable, up_down, sat_mode, clear_flag;
  logic [7:0] datain;
  logic [3:0] step;

  logic [7:0] dout0, dout1;
  logic       wrap0, wrap1, ovf0, ovf1, amax0, amax1, amin0, amin1;

  int n_checks = 0;
  int n_pass   = 0;

  int mmax[2] = '{9, 255};
  int mcnt[2];
  bit mwrap[2];
  bit movf[2];

  always #5 clk = ~clk;

  counter_nbit_updown #(
    .WIDTH       (8),
    .STEP_W      (4),
    .MAX_VALUE   (8'd9),
    .RESET_VALUE (8'd5)
  ) u_dec (
    .clk (clk), .reset (reset), .load (load), .datain (datain), .enable (enable),
    .up_down (up_down), .step (step), .sat_mode (sat_mode), .clear_flag (clear_flag),
    .dataout (dout0), .wrap (wrap0), .overflow (ovf0), .at_max (amax0), .at_min (amin0)
  );

  counter_nbit_updown #(
    .WIDTH       (8),
    .STEP_W      (4),
    .MAX_VALUE   (8'd255),
    .RESET_VALUE (8'd5)
  ) u_full (
    .clk (clk), .reset (reset), .load (load), .datain (datain), .enable (enable),
    .up_down (up_down), .step (step), .sat_mode (sat_mode), .clear_flag (clear_flag),
    .dataout (dout1), .wrap (wrap1), .overflow (ovf1), .at_max (amax1), .at_min (amin1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Reference behaviour from the counting rules, in plain integer arithmetic.
  task automatic model_edge(input int k);
    int s;
    if (reset) begin
      mcnt[k] = 5; mwrap[k] = 0; movf[k] = 0;
    end else begin
      mwrap[k] = 0;
      if (load) begin
        if (int'(datain) > mmax[k]) begin mcnt[k] = mmax[k]; mwrap[k] = 1; end
        else mcnt[k] = int'(datain);
      end else if (enable) begin
        if (up_down) begin
          s = mcnt[k] + int'(step);
          if (s > mmax[k]) begin
            mwrap[k] = 1;
            mcnt[k]  = sat_mode ? mmax[k] : s - (mmax[k] + 1);
          end else mcnt[k] = s;
        end else begin
          if (int'(step) > mcnt[k]) begin
            mwrap[k] = 1;
            mcnt[k]  = sat_mode ? 0 : mcnt[k] + mmax[k] + 1 - int'(step);
          end else mcnt[k] = mcnt[k] - int'(step);
        end
      end
      movf[k] = (movf[k] && !clear_flag) || mwrap[k];
    end
  endtask

  task automatic compare_all();
    check("dec.dataout",  32'(dout0), 32'(mcnt[0]));
    check("dec.wrap",     32'(wrap0), 32'(mwrap[0]));
    check("dec.overflow", 32'(ovf0),  32'(movf[0]));
    check("dec.at_max",   32'(amax0), 32'(mcnt[0] == mmax[0]));
    check("dec.at_min",   32'(amin0), 32'(mcnt[0] == 0));
    check("full.dataout", 32'(dout1), 32'(mcnt[1]));
    check("full.wrap",    32'(wrap1), 32'(mwrap[1]));
    check("full.overflow",32'(ovf1),  32'(movf[1]));
    check("full.at_max",  32'(amax1), 32'(mcnt[1] == mmax[1]));
    check("full.at_min",  32'(amin1), 32'(mcnt[1] == 0));
  endtask

  // Apply one set of inputs across a rising edge, then check both counters.
  task automatic cyc(input logic rst, input logic ld, input logic [7:0] din, input logic en,
                     input logic ud, input logic [3:0] st, input logic sm, input logic clr);
    reset = rst; load = ld; datain = din; enable = en;
    up_down = ud; step = st; sat_mode = sm; clear_flag = clr;
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; datain = '0; enable = 1'b0;
    up_down = 1'b1; step = '0; sat_mode = 1'b0; clear_flag = 1'b0;
    mcnt = '{0, 0}; mwrap = '{0, 0}; movf = '{0, 0};

    // Reset beats a simultaneous load.
    cyc(1, 1, 8'd9, 0, 1, 4'd0, 0, 0);
    check("reset.dataout", 32'(dout0), 32'd5);
    check("reset.wrap",    32'(wrap0), 32'd0);
    check("reset.ovf",     32'(ovf0),  32'd0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 8'd0, 0, 1, 4'd1, 0, 0);
    check("hold.dataout", 32'(dout1), 32'd5);

    // Decade wrap: 8 -> 9 -> 0.
    cyc(0, 1, 8'd8, 0, 1, 4'd0, 0, 0);
    cyc(0, 0, 8'd0, 1, 1, 4'd1, 0, 0);
    check("dec9.at_max", 32'(amax0), 32'd1);
    cyc(0, 0, 8'd0, 1, 1, 4'd1, 0, 0);
    check("dec0.dataout", 32'(dout0), 32'd0);
    check("dec0.wrap",    32'(wrap0), 32'd1);
    check("dec0.ovf",     32'(ovf0),  32'd1);
    cyc(0, 0, 8'd0, 0, 1, 4'd1, 0, 0);
    check("dec0.wrap_drop", 32'(wrap0), 32'd0);

    // Down wrap with a large step: 2 - 5 -> 7 (mod 10), 253 (mod 256).
    cyc(0, 1, 8'd2, 0, 0, 4'd0, 0, 0);
    cyc(0, 0, 8'd0, 1, 0, 4'd5, 0, 0);
    check("dnwrap.dataout", 32'(dout0), 32'd7);
    check("dnwrap.full",    32'(dout1), 32'd253);

    // Saturate at 255, repeat, then back down.
    cyc(0, 1, 8'd250, 0, 1, 4'd0, 1, 0);
    cyc(0, 0, 8'd0, 1, 1, 4'd8, 1, 0);
    check("sat1.dataout", 32'(dout1), 32'd255);
    cyc(0, 0, 8'd0, 1, 1, 4'd8, 1, 0);
    check("sat2.wrap", 32'(wrap1), 32'd1);
    cyc(0, 0, 8'd0, 1, 0, 4'd3, 1, 0);
    check("sat3.dataout", 32'(dout1), 32'd252);
    check("sat3.wrap",    32'(wrap1), 32'd0);

    // Load clamps and beats enable.
    cyc(0, 1, 8'd12, 1, 1, 4'd1, 0, 0);
    check("clamp.dataout", 32'(dout0), 32'd9);
    check("clamp.wrap",    32'(wrap0), 32'd1);
    cyc(0, 1, 8'd3, 0, 1, 4'd0, 0, 0);
    check("load3.wrap", 32'(wrap0), 32'd0);

    // Flag race: set beats clear on the same edge; a quiet clear then drops it.
    cyc(0, 0, 8'd0, 0, 1, 4'd0, 0, 1);
    cyc(0, 1, 8'd9, 0, 1, 4'd0, 0, 0);
    cyc(0, 0, 8'd0, 1, 1, 4'd1, 0, 1);
    check("race.ovf_set",   32'(ovf0), 32'd1);
    check("race.ovf_clear", 32'(ovf1), 32'd0);
    cyc(0, 0, 8'd0, 0, 1, 4'd0, 0, 1);
    check("quiet.ovf", 32'(ovf0), 32'd0);

    // Reset mid-count, then resume from the reset value.
    cyc(1, 0, 8'd0, 1, 1, 4'd3, 0, 0);
    cyc(0, 0, 8'd0, 1, 1, 4'd3, 0, 0);
    check("resume.dataout", 32'(dout0), 32'd8);

    // Randomised traffic; step kept within the smaller modulus.
    for (int i = 0; i < 500; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0), d,
          ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom_range(0, 9)),
          1'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_counter_nbit_updown

// File: doc/counter_nbit_updown.md
# counter_nbit_updown

Parametrised successor to the team's 16-bit load/increment counter. It holds a WIDTH-bit count that can be loaded, held, or stepped up or down by a programmable step. A modulus limit and a wrap/saturate mode are selectable, and wrap events are flagged. It serves as the program counter, loop counter, and timer base in the microprocessor datapath.

## Interface
- WIDTH, 16, count width in bits (2..32)
- STEP_W, 4, width of step input
- MAX_VALUE, 2**WIDTH-1, highest legal count; range is 0..MAX_VALUE
- RESET_VALUE, 0, count after reset; must be ≤ MAX_VALUE
- clk  in  1  rising-edge clock, the only clock
- reset  in  1  synchronous, active-high; sampled on rising clk
- load  in  1  load datain on the next edge
- datain  in  WIDTH  load value
- enable  in  1  count on the next edge (ignored when load=1)
- up_down  in  1  1 = up, 0 = down
- step  in  STEP_W  increment magnitude; step=0 holds the count
- sat_mode  in  1  0 = wrap at limits, 1 = saturate at limits
- clear_flag  in  1  clear the sticky overflow flag
- dataout  out  WIDTH  current count (registered)
- wrap  out  1  one-cycle pulse: the last update wrapped or saturated
- overflow  out  1  sticky: any wrap/saturate event since the last clear or reset
- at_max  out  1  dataout == MAX_VALUE
- at_min  out  1  dataout == 0

## Operation
- Priority per edge: reset > load > enable > hold.
- **reset**: dataout=RESET_VALUE, wrap=0, overflow=0.
- **load**:
  - dataout = min(datain, MAX_VALUE).
  - A clamped load (datain > MAX_VALUE) sets wrap=1 and sets overflow.
  - An unclamped load sets wrap=0.
- **enable, up**: let s = count + step, computed at WIDTH+1 bits.
  - If s ≤ MAX_VALUE: next count = s.
  - Else if wrap mode: next count = s − (MAX_VALUE+1).
  - Else (saturate): next count = MAX_VALUE.
  - A limit event (either of the last two cases) sets wrap=1 and sets overflow.
- **enable, down**:
  - If step ≤ count: next count = count − step.
  - Else if wrap mode: next count = count + (MAX_VALUE+1) − step.
  - Else (saturate): next count = 0.
  - A limit event sets wrap=1 and sets overflow.
- **Saturate-mode corner case**: saturate mode sitting at a limit and stepping further counts as an event on every such edge. So wrap=1 repeats while the count is pinned.
- **step constraint**: step must be ≤ MAX_VALUE. A larger step is illegal; assert it in simulation and do not define the result.
- **step = 0 with enable**: count unchanged, wrap=0.
- **hold** (no load, no enable): count unchanged, wrap=0.
- **overflow flag**:
  - Cleared by clear_flag on an edge.
  - If clear_flag and a new event occur on the same edge, set wins and overflow=1.
- **at_max / at_min**: combinational decodes of the dataout register only.
- **Reset mid-count**: reset overrides any load or enable on the same edge. Counting resumes from RESET_VALUE on the first edge with reset=0.

## Timing
- Latency: 1 clk from load/enable sampling to the new dataout.
- wrap is registered and aligned with the dataout value it describes. It is high for exactly one cycle per event unless events repeat.
- overflow updates on the same edge as the event that sets it.
- No handshake; every input is sampled on every rising edge. No combinational path from inputs to outputs.
- Back-to-back enable counts on every cycle at full rate.

## Structure
- **Shared package** `counter_pkg`:
  - Mode constants MODE_WRAP=1'b0 and MODE_SAT=1'b1.
  - Direction constants DIR_DOWN=1'b0 and DIR_UP=1'b1.
- **Sub-module** `counter_next_calc`:
  - Purely combinational.
  - Takes count, step, up_down, sat_mode and MAX_VALUE.
  - Returns next_count and limit_event.
  - The top level holds the registers, load clamp, priority and flags.
- Expected size: ~150–250 lines of RTL total.

## Test plan
- **Reset/hold**: WIDTH=8, RESET_VALUE=5; assert reset with load=1 and datain=9 → dataout=5, wrap=0, overflow=0. With enable=0 → dataout stays 5 across 10 cycles.
- **Decade wrap**: MAX_VALUE=9, up, step=1, wrap mode from 8 → 9 (at_max=1), then 0 with wrap=1 for one cycle and overflow=1.
- **Down wrap, large step**: MAX_VALUE=9, count=2, step=5, down, wrap mode → dataout=7, wrap=1.
- **Saturate**: MAX_VALUE=255, count=250, step=8, up, sat_mode=1 → 255, wrap=1. Next edge also gives 255, wrap=1. Then down with step=3 → 252, wrap=0.
- **Load clamp/priority**: MAX_VALUE=9; load=1, enable=1, datain=12 → dataout=9, wrap=1. Load datain=3 → dataout=3, wrap=0.
- **Flag race**: clear_flag=1 on an edge with an up-wrap event → overflow stays 1. clear_flag=1 on the next quiet edge → overflow=0.
